branch_ctrl: RTL and testbench

Sequencer for the ID-stage branch resolution path. Detects operand hazards between the branch in ID and producers in EX/MEM, then stalls or forwards so the jump detection unit only resolves with valid operands. Turns a taken resolution into a flush plus a registered, handshaked redirect to instruction fetch. Keeps saturating performance counters for branch stalls and taken branches.

---
 rtl/branch_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_branch_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// Branch resolution sequencer for the ID stage: operand hazard stall/forward,
// taken-branch flush plus a handshaked redirect to fetch, and saturating perf counters.
module branch_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_branch,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_reg_write,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             jd_pc_jump,
  input  logic [31:0]      jd_pc_jump_addr,
  input  logic             if_redirect_ready,
  output logic             fwd_rs1,
  output logic             fwd_rs2,
  output logic             stall,
  output logic             ex_bubble,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_addr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  input  logic             perf_clr
);

  typedef enum logic [0:0] {
    RESOLVE  = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  state_t            state_r;
  logic              redirect_valid_r;
  logic [31:0]       redirect_addr_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [CNT_W-1:0]  taken_cnt_r;

  logic              check_s;
  logic              ex_m1_s;
  logic              ex_m2_s;
  logic              mem_m1_s;
  logic              mem_m2_s;
  logic              haz_s;
  logic              fwd1_s;
  logic              fwd2_s;
  logic              stall_s;
  logic              bubble_s;
  logic              flush_s;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // x0 never carries a dependency, so a zero index can not match a producer
  function automatic logic src_match(input logic       uses,
                                     input logic [4:0] idx,
                                     input logic       wr,
                                     input logic [4:0] rd);
    return uses & (idx != 5'd0) & wr & (idx == rd);
  endfunction

  // Hazard detection, forwarding select and flush decision
  always_comb begin
    check_s  = 1'b0;
    ex_m1_s  = 1'b0;
    ex_m2_s  = 1'b0;
    mem_m1_s = 1'b0;
    mem_m2_s = 1'b0;
    haz_s    = 1'b0;
    fwd1_s   = 1'b0;
    fwd2_s   = 1'b0;
    stall_s  = 1'b0;
    bubble_s = 1'b0;
    flush_s  = 1'b0;

    check_s = id_valid & id_branch & (state_r == RESOLVE);
    if (check_s) begin
      ex_m1_s  = src_match(id_uses_rs1, id_rs1, ex_reg_write, ex_rd);
      ex_m2_s  = src_match(id_uses_rs2, id_rs2, ex_reg_write, ex_rd);
      mem_m1_s = src_match(id_uses_rs1, id_rs1, mem_reg_write, mem_rd);
      mem_m2_s = src_match(id_uses_rs2, id_rs2, mem_reg_write, mem_rd);
    end else begin
      ex_m1_s  = 1'b0;
      ex_m2_s  = 1'b0;
      mem_m1_s = 1'b0;
      mem_m2_s = 1'b0;
    end

    // A load in MEM has no data yet; an ALU result in MEM can be forwarded
    haz_s  = ex_m1_s | ex_m2_s | ((mem_m1_s | mem_m2_s) & mem_mem_read);
    fwd1_s = mem_m1_s & ~mem_mem_read & ~ex_m1_s;
    fwd2_s = mem_m2_s & ~mem_mem_read & ~ex_m2_s;

    case (state_r)
      RESOLVE: begin
        stall_s  = haz_s;
        bubble_s = haz_s;
        flush_s  = check_s & ~haz_s & jd_pc_jump;
      end
      REDIRECT: begin
        stall_s  = 1'b1;
        bubble_s = 1'b0;
        flush_s  = 1'b0;
      end
      default: begin
        stall_s  = 1'b0;
        bubble_s = 1'b0;
        flush_s  = 1'b0;
      end
    endcase
  end

  // Redirect FSM: latch target on a taken resolution, hold until fetch accepts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r          <= RESOLVE;
      redirect_valid_r <= 1'b0;
      redirect_addr_r  <= 32'h0000_0000;
    end else begin
      case (state_r)
        RESOLVE: begin
          if (flush_s) begin
            state_r          <= REDIRECT;
            redirect_valid_r <= 1'b1;
            redirect_addr_r  <= jd_pc_jump_addr;
          end else begin
            state_r          <= RESOLVE;
            redirect_valid_r <= 1'b0;
          end
        end
        REDIRECT: begin
          if (redirect_valid_r && if_redirect_ready) begin
            state_r          <= RESOLVE;
            redirect_valid_r <= 1'b0;
          end else begin
            state_r          <= REDIRECT;
            redirect_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r          <= RESOLVE;
          redirect_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Saturating performance counters; clear wins over a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      taken_cnt_r <= {CNT_W{1'b0}};
    end else if (perf_clr) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      taken_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (haz_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_s && (taken_cnt_r != CNT_MAX)) begin
        taken_cnt_r <= taken_cnt_r + CNT_ONE;
      end else begin
        taken_cnt_r <= taken_cnt_r;
      end
    end
  end

  assign fwd_rs1        = fwd1_s;
  assign fwd_rs2        = fwd2_s;
  assign stall          = stall_s;
  assign ex_bubble      = bubble_s;
  assign flush          = flush_s;
  assign redirect_valid = redirect_valid_r;
  assign redirect_addr  = redirect_addr_r;
  assign stall_cnt      = stall_cnt_r;
  assign taken_cnt      = taken_cnt_r;

  branch_ctrl_chk u_chk (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush_s),
    .stall             (stall_s),
    .redirect_valid    (redirect_valid_r),
    .redirect_addr     (redirect_addr_r),
    .if_redirect_ready (if_redirect_ready)
  );

endmodule

// Protocol properties of the redirect handshake and flush/stall exclusivity.
module branch_ctrl_chk (
  input logic        clk,
  input logic        rst,
  input logic        flush,
  input logic        stall,
  input logic        redirect_valid,
  input logic [31:0] redirect_addr,
  input logic        if_redirect_ready
);

  a_hold: assert property (@(posedge clk) disable iff (rst)
    (redirect_valid && !if_redirect_ready) |=> (redirect_valid && $stable(redirect_addr)));

  a_flush_no_stall: assert property (@(posedge clk) disable iff (rst)
    !(flush && stall));

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed, table-driven bench for branch_ctrl with hand-written multi-cycle sequences.
module tb_branch_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid, id_branch, id_uses_rs1, id_uses_rs2;
  logic [4:0]  id_rs1, id_rs2;
  logic        ex_reg_write, ex_mem_read;
  logic [4:0]  ex_rd;
  logic        mem_reg_write, mem_mem_read;
  logic [4:0]  mem_rd;
  logic        jd_pc_jump;
  logic [31:0] jd_pc_jump_addr;
  logic        if_redirect_ready;
  logic        fwd_rs1, fwd_rs2, stall, ex_bubble, flush;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic [15:0] stall_cnt, taken_cnt;
  logic        perf_clr;

  int pass_cnt = 0;
  int total_cnt = 0;

  branch_ctrl #(.CNT_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .id_valid          (id_valid),
    .id_branch         (id_branch),
    .id_uses_rs1       (id_uses_rs1),
    .id_uses_rs2       (id_uses_rs2),
    .id_rs1            (id_rs1),
    .id_rs2            (id_rs2),
    .ex_reg_write      (ex_reg_write),
    .ex_mem_read       (ex_mem_read),
    .ex_rd             (ex_rd),
    .mem_reg_write     (mem_reg_write),
    .mem_mem_read      (mem_mem_read),
    .mem_rd            (mem_rd),
    .jd_pc_jump        (jd_pc_jump),
    .jd_pc_jump_addr   (jd_pc_jump_addr),
    .if_redirect_ready (if_redirect_ready),
    .fwd_rs1           (fwd_rs1),
    .fwd_rs2           (fwd_rs2),
    .stall             (stall),
    .ex_bubble         (ex_bubble),
    .flush             (flush),
    .redirect_valid    (redirect_valid),
    .redirect_addr     (redirect_addr),
    .stall_cnt         (stall_cnt),
    .taken_cnt         (taken_cnt),
    .perf_clr          (perf_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      name;
    logic       vld, br, u1, u2;
    logic [4:0] rs1, rs2;
    logic       exw, exm;
    logic [4:0] exrd;
    logic       memw, memm;
    logic [4:0] memrd;
    logic       jmp;
    logic [4:0] exp;   // {fwd_rs1, fwd_rs2, stall, ex_bubble, flush}
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic idle();
    id_valid = 1'b0; id_branch = 1'b0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_rd = 5'd0;
    jd_pc_jump = 1'b0; jd_pc_jump_addr = 32'h0000_0000;
    if_redirect_ready = 1'b0; perf_clr = 1'b0;
  endtask

  task automatic branch(input logic [4:0] rs1, input logic [4:0] rs2);
    id_valid = 1'b1; id_branch = 1'b1; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    id_rs1 = rs1; id_rs2 = rs2;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0]  = '{"ex_alu_rs1",    1'b1,1'b1,1'b1,1'b1, 5'd5,5'd6, 1'b1,1'b0,5'd5, 1'b0,1'b0,5'd0, 1'b0, 5'b00110};
    vecs[1]  = '{"mem_alu_rs1",   1'b1,1'b1,1'b1,1'b1, 5'd5,5'd6, 1'b0,1'b0,5'd0, 1'b1,1'b0,5'd5, 1'b0, 5'b10000};
    vecs[2]  = '{"ex_load_rs2",   1'b1,1'b1,1'b1,1'b1, 5'd1,5'd7, 1'b1,1'b1,5'd7, 1'b0,1'b0,5'd0, 1'b0, 5'b00110};
    vecs[3]  = '{"mem_load_rs2",  1'b1,1'b1,1'b1,1'b1, 5'd1,5'd7, 1'b0,1'b0,5'd0, 1'b1,1'b1,5'd7, 1'b0, 5'b00110};
    vecs[4]  = '{"x0_no_haz",     1'b1,1'b1,1'b1,1'b1, 5'd0,5'd6, 1'b1,1'b0,5'd0, 1'b1,1'b0,5'd0, 1'b0, 5'b00000};
    vecs[5]  = '{"ex_over_mem",   1'b1,1'b1,1'b1,1'b1, 5'd5,5'd6, 1'b1,1'b0,5'd5, 1'b1,1'b0,5'd5, 1'b0, 5'b00110};
    vecs[6]  = '{"jal_no_uses",   1'b1,1'b1,1'b0,1'b0, 5'd5,5'd5, 1'b1,1'b0,5'd5, 1'b0,1'b0,5'd0, 1'b0, 5'b00000};
    vecs[7]  = '{"id_invalid",    1'b0,1'b1,1'b1,1'b1, 5'd5,5'd6, 1'b1,1'b0,5'd5, 1'b1,1'b0,5'd6, 1'b0, 5'b00000};
    vecs[8]  = '{"not_branch",    1'b1,1'b0,1'b1,1'b1, 5'd5,5'd6, 1'b1,1'b0,5'd5, 1'b1,1'b0,5'd6, 1'b0, 5'b00000};
    vecs[9]  = '{"haz_beats_jump",1'b1,1'b1,1'b1,1'b1, 5'd5,5'd6, 1'b1,1'b0,5'd5, 1'b0,1'b0,5'd0, 1'b1, 5'b00110};
    vecs[10] = '{"mem_alu_rs2",   1'b1,1'b1,1'b1,1'b1, 5'd4,5'd3, 1'b0,1'b0,5'd0, 1'b1,1'b0,5'd3, 1'b0, 5'b01000};
    vecs[11] = '{"ex_no_write",   1'b1,1'b1,1'b1,1'b1, 5'd5,5'd6, 1'b0,1'b0,5'd5, 1'b0,1'b0,5'd0, 1'b0, 5'b00000};
    vecs[12] = '{"mem_alu_both",  1'b1,1'b1,1'b1,1'b1, 5'd9,5'd9, 1'b0,1'b0,5'd0, 1'b1,1'b0,5'd9, 1'b0, 5'b11000};

    // Reset values, and combinational outputs live during reset
    idle();
    rst = 1'b1;
    branch(5'd5, 5'd6);
    ex_reg_write = 1'b1; ex_rd = 5'd5;
    #2;
    check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("rst_redirect_addr", redirect_addr, 32'd0);
    check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    check("rst_taken_cnt", {16'd0, taken_cnt}, 32'd0);
    check("rst_comb_stall", {31'd0, stall}, 32'd1);
    next();
    next();
    idle();
    rst = 1'b0;

    foreach (vecs[i]) begin
      next();
      id_valid = vecs[i].vld; id_branch = vecs[i].br;
      id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      ex_reg_write = vecs[i].exw; ex_mem_read = vecs[i].exm; ex_rd = vecs[i].exrd;
      mem_reg_write = vecs[i].memw; mem_mem_read = vecs[i].memm; mem_rd = vecs[i].memrd;
      jd_pc_jump = vecs[i].jmp; jd_pc_jump_addr = 32'h0000_2000;
      @(negedge clk);
      check(vecs[i].name, {27'd0, fwd_rs1, fwd_rs2, stall, ex_bubble, flush}, {27'd0, vecs[i].exp});
    end
    next();
    idle();
    @(negedge clk);
    check("table_stall_cnt", {16'd0, stall_cnt}, 32'd5);
    check("table_taken_cnt", {16'd0, taken_cnt}, 32'd0);

    // ALU producer in EX: one stall, then forwarded from MEM
    next();
    branch(5'd5, 5'd6);
    ex_reg_write = 1'b1; ex_rd = 5'd5;
    @(negedge clk);
    check("alu_c1_stall_bubble", {30'd0, stall, ex_bubble}, 32'd3);
    next();
    ex_reg_write = 1'b0; ex_rd = 5'd0;
    mem_reg_write = 1'b1; mem_rd = 5'd5;
    @(negedge clk);
    check("alu_c2_fwd_stall_flush", {29'd0, fwd_rs1, stall, flush}, 32'd4);

    // Clear counters with no event pending
    next();
    idle();
    perf_clr = 1'b1;
    next();
    perf_clr = 1'b0;
    @(negedge clk);
    check("perf_clr_stall_cnt", {16'd0, stall_cnt}, 32'd0);

    // Load producer in EX: two stalls, then resolve without forwarding
    next();
    branch(5'd1, 5'd7);
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd7;
    @(negedge clk);
    check("lw_c1_stall", {31'd0, stall}, 32'd1);
    next();
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    mem_reg_write = 1'b1; mem_mem_read = 1'b1; mem_rd = 5'd7;
    @(negedge clk);
    check("lw_c2_stall", {31'd0, stall}, 32'd1);
    next();
    mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_rd = 5'd0;
    @(negedge clk);
    check("lw_c3_fwd_stall", {30'd0, fwd_rs2, stall}, 32'd0);
    check("lw_stall_cnt", {16'd0, stall_cnt}, 32'd2);

    // Taken branch with fetch not ready for three redirect cycles
    next();
    idle();
    branch(5'd1, 5'd2);
    jd_pc_jump = 1'b1; jd_pc_jump_addr = 32'h0000_1040;
    @(negedge clk);
    check("tk_flush", {29'd0, flush, stall, redirect_valid}, 32'd4);
    for (int k = 0; k < 4; k++) begin
      next();
      branch(5'd1, 5'd2);
      ex_reg_write = 1'b1; ex_rd = 5'd1;
      jd_pc_jump = 1'b1; jd_pc_jump_addr = 32'hDEAD_0000;
      if_redirect_ready = (k == 3) ? 1'b1 : 1'b0;
      @(negedge clk);
      check("rd_valid", {31'd0, redirect_valid}, 32'd1);
      check("rd_addr", redirect_addr, 32'h0000_1040);
      check("rd_stall_flush_bubble", {29'd0, stall, flush, ex_bubble}, 32'd4);
    end
    next();
    idle();
    @(negedge clk);
    check("rd_done_valid_stall", {30'd0, redirect_valid, stall}, 32'd0);
    check("rd_taken_cnt", {16'd0, taken_cnt}, 32'd1);
    check("rd_stall_cnt", {16'd0, stall_cnt}, 32'd2);

    // Second taken branch proves RESOLVE, then reset mid-REDIRECT
    next();
    branch(5'd1, 5'd2);
    jd_pc_jump = 1'b1; jd_pc_jump_addr = 32'h0000_3000;
    @(negedge clk);
    check("tk2_flush", {31'd0, flush}, 32'd1);
    next();
    idle();
    @(negedge clk);
    check("tk2_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", {31'd0, redirect_valid}, 32'd0);
    check("rst_mid_stall", {31'd0, stall}, 32'd0);
    check("rst_mid_counters", {stall_cnt, taken_cnt}, 32'd0);
    next();
    rst = 1'b0;

    // Long hazard stream saturates stall_cnt, then clear during a stall
    branch(5'd5, 5'd6);
    ex_reg_write = 1'b1; ex_rd = 5'd5;
    repeat (65540) @(posedge clk);
    @(negedge clk);
    check("sat_stall_cnt", {16'd0, stall_cnt}, 32'h0000_FFFF);
    next();
    perf_clr = 1'b1;
    @(negedge clk);
    check("clr_during_stall", {31'd0, stall}, 32'd1);
    next();
    perf_clr = 1'b0;
    idle();
    @(negedge clk);
    check("clr_wins_stall_cnt", {16'd0, stall_cnt}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
